mod_n_counter_arbiter: RTL and testbench

MOD_N_COUNTER_ARBITER -- requirements
Module: mod_n_counter_arbiter

---
 rtl/mod_n_pkg.sv | 8 +
 rtl/mod_n_counter_sync.sv | 23 ++
 rtl/mod_n_counter_arbiter.sv | 56 +++++
 tb/tb_mod_n_counter_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mod_n_pkg.sv
// mod_n_pkg: shared defaults and modulo-N increment helper for the counter arbiter.
package mod_n_pkg;
   localparam int DEF_MODULUS = 5;
   localparam int DEF_NUM_REQ = 4;
   function automatic int unsigned next_count(input int unsigned value, input int unsigned modulus);
      return (value >= modulus - 1) ? 0 : value + 1;
   endfunction
endpackage

// File: rtl/mod_n_counter_sync.sv
// mod_n_counter_sync: modulo-MODULUS counter with async clear, sync clear and increment enable.
module mod_n_counter_sync
   import mod_n_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic                       clk_i,
   input  logic                       clear_i,
   input  logic                       sync_clr_i,
   input  logic                       incr_i,
   output logic [$clog2(MODULUS)-1:0] count_o
);
   localparam int CW = $clog2(MODULUS);
   logic [CW-1:0] count_q, count_d;
   always_comb begin
      count_d = sync_clr_i ? '0 : incr_i ? CW'(next_count(32'(count_q), MODULUS)) : count_q;
   end
   always_ff @(posedge clk_i or posedge clear_i) begin
      if (clear_i) count_q <= '0;
      else         count_q <= count_d;
   end
   assign count_o = count_q;
endmodule

// File: rtl/mod_n_counter_arbiter.sv
// mod_n_counter_arbiter: round-robin arbiter handing out modulo-N ticket numbers,
// one grant per cycle, with sync clear and hold controls.
module mod_n_counter_arbiter
   import mod_n_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS,
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic                       clk_i,
   input  logic                       clear_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic                       sync_clr_i,
   input  logic                       hold_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(MODULUS)-1:0] ticket_o,
   output logic [$clog2(MODULUS)-1:0] count_o,
   output logic                       wrap_o
);
   localparam int CW = $clog2(MODULUS);
   localparam int PW = $clog2(NUM_REQ);
   logic [PW-1:0] ptr_q, ptr_d, win, idx;
   logic          found, en;
   logic [CW-1:0] count;
   // Search starts at ptr and wraps so the last winner gets lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(ptr_q) + i) % NUM_REQ);
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   always_comb begin
      en    = found && !hold_i && !sync_clr_i && !clear_i;
      ptr_d = sync_clr_i ? '0 : en ? ((win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
   end
   always_ff @(posedge clk_i or posedge clear_i) begin
      if (clear_i) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
   mod_n_counter_sync #(.MODULUS(MODULUS)) u_cnt (
      .clk_i      (clk_i),
      .clear_i    (clear_i),
      .sync_clr_i (sync_clr_i),
      .incr_i     (en),
      .count_o    (count)
   );
   assign gnt_o    = en ? NUM_REQ'(1) << win : '0;
   assign ticket_o = en ? count : '0;
   assign wrap_o   = en && (count == CW'(MODULUS - 1));
   assign count_o  = count;
endmodule

// File: tb/tb_mod_n_counter_arbiter.sv
// tb_mod_n_counter_arbiter: directed and random checks against a reference model
// using a queue of expected grant results.
module tb_mod_n_counter_arbiter;
   logic       clk_i, clear_i, sync_clr_i, hold_i, wrap_o;
   logic [3:0] req_i, gnt_o;
   logic [2:0] ticket_o, count_o;
   typedef struct packed {logic [3:0] gnt; logic [2:0] ticket; logic wrap;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int m_count = 0, m_ptr = 0;
   logic [3:0] last_gnt;
   logic [2:0] last_ticket;
   logic       last_wrap;
   mod_n_counter_arbiter #(.MODULUS(5), .NUM_REQ(4)) dut (
      .clk_i      (clk_i),
      .clear_i    (clear_i),
      .req_i      (req_i),
      .sync_clr_i (sync_clr_i),
      .hold_i     (hold_i),
      .gnt_o      (gnt_o),
      .ticket_o   (ticket_o),
      .count_o    (count_o),
      .wrap_o     (wrap_o)
   );
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // Drive one cycle, check combinational outputs, then advance the model past the edge.
   task automatic step(input logic [3:0] r, input logic h, input logic s);
      exp_t e;
      int w;
      w = -1;
      e = '0;
      req_i = r;
      hold_i = h;
      sync_clr_i = s;
      if (!h && !s)
         for (int i = 0; i < 4; i++)
            if (w < 0 && r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      if (w >= 0) begin
         e.gnt = 4'(1 << w);
         e.ticket = 3'(m_count);
         e.wrap = (m_count == 4);
      end
      q.push_back(e);
      #1;
      e = q.pop_front();
      last_gnt = gnt_o;
      last_ticket = ticket_o;
      last_wrap = wrap_o;
      chk("gnt", gnt_o, e.gnt);
      chk("ticket", ticket_o, e.ticket);
      chk("wrap", wrap_o, e.wrap);
      chk("count", count_o, m_count);
      chk("range", count_o < 3'd5, 1);
      @(posedge clk_i);
      if (s) begin
         m_count = 0;
         m_ptr = 0;
      end else if (w >= 0) begin
         m_count = (m_count + 1) % 5;
         m_ptr = (w + 1) % 4;
      end
      #1;
   endtask
   initial begin
      logic [3:0] rr_exp [5];
      logic [2:0] tk_exp [6];
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      tk_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      clear_i = 1'b1;
      req_i = 4'b1111;
      hold_i = 1'b0;
      sync_clr_i = 1'b0;
      #2;
      chk("rst_count", count_o, 0);
      chk("rst_gnt", gnt_o, 0);
      chk("rst_ticket", ticket_o, 0);
      @(posedge clk_i);
      #1;
      chk("rst_hold_gnt", gnt_o, 0);
      clear_i = 1'b0;
      // round-robin from reset
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b0, 1'b0);
         chk("rr_gnt", last_gnt, rr_exp[i]);
      end
      // single requester, wraps on 5th grant
      step(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(4'b0001, 1'b0, 1'b0);
         chk("single_ticket", last_ticket, tk_exp[i]);
         chk("single_wrap", last_wrap, (i == 4));
      end
      chk("single_count", count_o, 1);
      // ptr is now 1: skip idle requesters
      step(4'b1001, 1'b0, 1'b0);
      chk("skip_a", last_gnt, 4'b1000);
      step(4'b1001, 1'b0, 1'b0);
      chk("skip_b", last_gnt, 4'b0001);
      // sync clear beats hold and req
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      chk("clr_pre_count", count_o, 2);
      step(4'b0100, 1'b1, 1'b1);
      chk("clr_gnt", last_gnt, 0);
      chk("clr_count", count_o, 0);
      step(4'b1111, 1'b0, 1'b0);
      chk("clr_ptr", last_gnt, 4'b0001);
      // hold suppresses grants
      for (int i = 0; i < 3; i++) begin
         step(4'b0010, 1'b1, 1'b0);
         chk("hold_gnt", last_gnt, 0);
         chk("hold_count", count_o, 1);
      end
      step(4'b0010, 1'b0, 1'b0);
      chk("hold_release", last_gnt, 4'b0010);
      // reach count=3 ptr=2, then async clear mid-cycle
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      chk("async_pre", count_o, 3);
      #2;
      req_i = 4'b1111;
      clear_i = 1'b1;
      #1;
      chk("async_count", count_o, 0);
      chk("async_gnt", gnt_o, 0);
      chk("async_wrap", wrap_o, 0);
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      m_count = 0;
      m_ptr = 0;
      step(4'b1111, 1'b0, 1'b0);
      chk("async_first", last_gnt, 4'b0001);
      // random traffic against the model
      for (int i = 0; i < 60; i++)
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
